// File: rtl/image_pixel_proc_if.sv
// Stream bundle for image_pixel_proc: frame control, input beat and output beat handshakes.
// The master side feeds pixels and consumes results; the slave side is the pixel processor.
interface image_pixel_proc_if #(
  parameter int DW  = 8,
  parameter int PPC = 2
);
  localparam int BW = 3 * DW * PPC;

  logic [2:0]    mode;
  logic [DW-1:0] value;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_hsync;
  logic          out_last;
  logic          frame_done;

  modport master (
    output mode, value, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_hsync, out_last, frame_done
  );

  modport slave (
    input  mode, value, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_hsync, out_last, frame_done
  );
endinterface

// File: rtl/image_pixel_proc.sv
// Two-stage streaming pixel processor. Stage 1 does the wide arithmetic
// (add, subtract, invert, luma sum); stage 2 saturates and selects the result.
// Mode and value are captured on the first beat of every frame so a frame is
// always processed with one consistent setting.
module image_pixel_proc #(
  parameter int DW    = 8,
  parameter int PPC   = 2,
  parameter int IMG_W = 768,
  parameter int IMG_H = 512
) (
  input logic               HCLK,
  input logic               HRESET,
  image_pixel_proc_if.slave bus
);

  localparam int NCH  = 3 * PPC;
  localparam int BW   = 3 * DW * PPC;
  localparam int COLS = IMG_W / PPC;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [DW-1:0] MAXV = '1;

  logic [CW-1:0] col_in;
  logic [RW-1:0] row_in;
  logic [2:0]    mode_lat;
  logic [DW-1:0] value_lat;

  logic                  s1_valid;
  logic                  s1_hsync;
  logic                  s1_last;
  logic [2:0]            s1_mode;
  logic [DW-1:0]         s1_value;
  logic [NCH-1:0][DW:0]  s1_pre;
  logic [PPC-1:0][DW-1:0] s1_gray;

  logic          s2_valid;
  logic          s2_hsync;
  logic          s2_last;
  logic [BW-1:0] s2_data;
  logic          done_q;

  logic s1_en, s2_en, in_xfer, out_xfer;
  logic first_beat, last_col, last_row;
  logic [2:0]    eff_mode;
  logic [DW-1:0] eff_value;
  logic [DW-1:0] chan;
  logic [NCH-1:0][DW:0]   pre_next;
  logic [PPC-1:0][DW-1:0] gray_next;
  logic [BW-1:0]          sel_next;

  // A stage may load when it is empty or when the stage after it is moving.
  assign s2_en = !s2_valid || bus.out_ready;
  assign s1_en = !s1_valid || s2_en;

  assign bus.in_ready   = !HRESET && s1_en;
  assign bus.out_valid  = !HRESET && s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_hsync  = bus.out_valid && s2_hsync;
  assign bus.out_last   = bus.out_valid && s2_last;
  assign bus.frame_done = done_q;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  assign first_beat = (col_in == '0) && (row_in == '0);
  assign last_col   = (col_in == CW'(COLS - 1));
  assign last_row   = (row_in == RW'(IMG_H - 1));

  // The first beat of a frame uses the live mode/value; later beats use the captured copy.
  assign eff_mode  = first_beat ? bus.mode  : mode_lat;
  assign eff_value = first_beat ? bus.value : value_lat;

  // Stage-1 arithmetic: one extra bit per channel keeps carry/borrow for stage-2 clamping.
  always_comb begin
    pre_next  = '0;
    gray_next = '0;
    chan      = '0;
    for (int p = 0; p < PPC; p++) begin
      gray_next[p] = DW'(((DW+2)'(bus.in_data[(3*p+2)*DW +: DW])
                        + ((DW+2)'(bus.in_data[(3*p+1)*DW +: DW]) << 1)
                        + (DW+2)'(bus.in_data[(3*p)*DW +: DW])) >> 2);
    end
    for (int c = 0; c < NCH; c++) begin
      chan = bus.in_data[c*DW +: DW];
      case (eff_mode)
        3'd1:    pre_next[c] = {1'b0, chan} + {1'b0, eff_value};
        3'd2:    pre_next[c] = {1'b0, chan} - {1'b0, eff_value};
        3'd3:    pre_next[c] = {1'b0, ~chan};
        default: pre_next[c] = {1'b0, chan};
      endcase
    end
  end

  // Stage-2 select: clamp add/subtract results and expand luma into threshold or gray.
  always_comb begin
    sel_next = '0;
    for (int c = 0; c < NCH; c++) begin
      case (s1_mode)
        3'd1:    sel_next[c*DW +: DW] = s1_pre[c][DW] ? MAXV : s1_pre[c][DW-1:0];
        3'd2:    sel_next[c*DW +: DW] = s1_pre[c][DW] ? '0 : s1_pre[c][DW-1:0];
        3'd4:    sel_next[c*DW +: DW] = (s1_gray[c/3] > s1_value) ? MAXV : '0;
        3'd5:    sel_next[c*DW +: DW] = s1_gray[c/3];
        default: sel_next[c*DW +: DW] = s1_pre[c][DW-1:0];
      endcase
    end
  end

  // Frame position counters and the per-frame mode/value capture.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      col_in    <= '0;
      row_in    <= '0;
      mode_lat  <= '0;
      value_lat <= '0;
    end else if (in_xfer) begin
      if (first_beat) begin
        mode_lat  <= bus.mode;
        value_lat <= bus.value;
      end
      if (last_col) begin
        col_in <= '0;
        row_in <= last_row ? '0 : row_in + RW'(1);
      end else begin
        col_in <= col_in + CW'(1);
      end
    end
  end

  // Stage-1 register: arithmetic results plus the flags and mode that travel with the beat.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1_valid <= 1'b0;
      s1_hsync <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= '0;
      s1_value <= '0;
      s1_pre   <= '0;
      s1_gray  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_hsync <= (col_in == '0);
        s1_last  <= last_col && last_row;
        s1_mode  <= eff_mode;
        s1_value <= eff_value;
        s1_pre   <= pre_next;
        s1_gray  <= gray_next;
      end
    end
  end

  // Stage-2 register: only loads on a real beat, so output holds steady while stalled.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s2_valid <= 1'b0;
      s2_hsync <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hsync <= s1_hsync;
        s2_last  <= s1_last;
        s2_data  <= sel_next;
      end
    end
  end

  // One-cycle pulse following the hand-off of the final beat of a frame.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      done_q <= 1'b0;
    end else begin
      done_q <= out_xfer && bus.out_last;
    end
  end

endmodule

// File: doc/image_pixel_proc.md
IMAGE_PIXEL_PROC -- requirements
Module: image_pixel_proc

Interface
REQ-001 SHALL have parameter DW, default 8, bits per colour channel.
REQ-002 SHALL have parameter PPC, default 2, pixels carried per beat (1..4).
REQ-003 SHALL have parameter IMG_W, default 768, pixels per line; IMG_W divisible by PPC.
REQ-004 SHALL have parameter IMG_H, default 512, lines per frame.
REQ-005 SHALL have port HCLK  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port mode  input  3  operation select, latched at frame start.
REQ-008 SHALL have port value  input  DW  brightness offset / threshold level, latched with mode.
REQ-009 SHALL have port in_valid  input  1  upstream beat valid.
REQ-010 SHALL have port in_ready  output  1  block accepts beat.
REQ-011 SHALL have port in_data  input  3*DW*PPC  pixels, pixel k at bits [3*DW*(k+1)-1 : 3*DW*k], each pixel {R,G,B}, R most significant.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-014 SHALL have port out_data  output  3*DW*PPC  processed pixels, same packing as in_data.
REQ-015 SHALL have port out_hsync  output  1  qualifies first beat of a line (valid only with out_valid).
REQ-016 SHALL have port out_last  output  1  qualifies last beat of a frame.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after last frame beat transfers.

Function
REQ-018 SHALL transfer input when in_valid&in_ready, output when out_valid&out_ready, both same HCLK edge.
REQ-019 SHALL implement 2-stage pipeline (S1 arithmetic, S2 saturate/select) with per-stage valid; latency exactly 2 cycles input transfer to out_valid when not stalled.
REQ-020 SHALL drive in_ready = !S2_valid | out_ready | !S1_valid (standard pipeline ready); no bubble inserted at full throughput: one beat per cycle sustained.
REQ-021 SHALL hold out_data, out_hsync, out_last stable while out_valid & !out_ready.
REQ-022 SHALL never drop or duplicate a beat under any in_valid/out_ready pattern.
REQ-023 SHALL apply per channel: mode 0 bypass; 1 x+value saturate at 2^DW-1; 2 x-value floor 0; 3 invert (2^DW-1)-x; 4 threshold: g=(R+2G+B)>>2 computed in DW+2 bits, all channels 2^DW-1 if g>value else 0; 5 grayscale: all channels g; 6,7 treated as bypass.
REQ-024 SHALL process all PPC pixels of a beat in parallel, independently.
REQ-025 SHALL latch mode/value on input transfer of beat col=0,row=0; changes mid-frame take effect only at next frame.
REQ-026 SHALL keep input counters col_in 0..IMG_W/PPC-1, row_in 0..IMG_H-1, advanced on input transfer, wrapping to 0/0 after last beat.
REQ-027 SHALL carry hsync/last flags down the pipeline with each beat: hsync when col_in=0, last when col_in=max and row_in=IMG_H-1.
REQ-028 SHALL assert frame_done for exactly one cycle, the cycle after the out_last beat transfers.
REQ-029 SHALL accept beats of the next frame back-to-back with the last beat of the current frame, using the newly latched mode for them only.

Reset
REQ-030 SHALL, while HRESET sampled high, clear both stage valids, counters, latched mode/value (to 0), and drive out_valid, out_hsync, out_last, frame_done, out_data, in_ready to 0.
REQ-031 SHALL drive in_ready=1 the first cycle after HRESET deasserts.
REQ-032 SHALL, on HRESET mid-frame, discard in-flight beats; next accepted beat is col=0,row=0.

Verification
REQ-033 Bypass, DW=8 PPC=2, out_ready=1, beat {10,20,30,40,50,60} -> identical out_data exactly 2 cycles later, out_hsync=1.
REQ-034 Mode1 value=200, pixel R=100 -> R=255; mode2 value=200, R=100 -> R=0; mode3 R=100 -> 155.
REQ-035 Mode4 value=99, RGB=(100,100,100) -> g=100 -> (255,255,255); RGB=(99,99,99) -> (0,0,0); mode5 RGB=(255,255,255) -> g=255, no overflow.
REQ-036 Random in_valid/out_ready toggling over full 4x2 frame (IMG_W=8,IMG_H=2,PPC=2) -> output sequence equals reference model, 8 beats, out_last on 8th, single frame_done pulse.
REQ-037 mode changed 0->3 at beat 3 of frame -> frame bypass throughout; next frame inverted from its first beat.
REQ-038 HRESET asserted with both stages full -> out_valid=0 next cycle, in_ready=1 after release, next out beat flagged out_hsync=1.
